// File: rtl/sram_read_streamer.sv
// Burst read client for a pipelined SRAM: one read per cycle, returned words streamed out with a last flag.
// Latency: command accept at cycle T gives first out_valid at T+NBPIPE+3; sustains one word per cycle.
// Backpressure: reads are only issued while FIFO occupancy plus in-flight reads leaves room, so nothing is dropped.

module sr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    output logic                     pop_vld,
    input  logic                     pop_rdy,
    output logic [WIDTH-1:0]         pop_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q;
    logic             empty, full, do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_rdy && !empty;
    // A pop in the same cycle frees the slot, so a push at full is still legal.
    assign do_push = push_vld && (!full || do_pop);

    assign pop_vld = !empty;
    assign pop_dat = empty ? '0 : mem_q[rptr_q];
    assign count   = cnt_q;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= push_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

module sram_read_streamer #(
    parameter int AWIDTH     = 12,
    parameter int DWIDTH     = 72,
    parameter int NBPIPE     = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [AWIDTH:0]   cmd_len,
    output logic              mem_enable,
    output logic [AWIDTH-1:0] read_address,
    input  logic [DWIDTH-1:0] read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    localparam int LAT = NBPIPE + 1;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int IW  = $clog2(LAT + 1);
    localparam int SW  = ((CW > IW) ? CW : IW) + 1;

    if (FIFO_DEPTH < LAT + 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least NBPIPE+2");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d, raddr_q;
    logic [AWIDTH:0]   rem_q, rem_d;
    logic [LAT-1:0]    tag_vld_q, tag_last_q;
    logic [IW-1:0]     inflight_q;
    logic              run_q, done_q, done_d;
    logic              issue, capture, pop, issue_ok;
    logic [CW-1:0]     fifo_count;
    logic [SW-1:0]     occ;

    assign capture  = tag_vld_q[LAT-1];
    assign pop      = out_valid && out_ready;
    // The current-cycle pop is deliberately not credited; this keeps the check independent of out_ready timing.
    assign occ      = SW'(fifo_count) + SW'(inflight_q);
    assign issue_ok = (occ < SW'(FIFO_DEPTH));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && run_q) begin
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                        addr_d  = cmd_addr;
                        rem_d   = cmd_len;
                    end
                end
            end
            S_ISSUE: begin
                if (issue_ok) begin
                    issue  = 1'b1;
                    addr_d = addr_q + AWIDTH'(1);
                    rem_d  = rem_q - (AWIDTH+1)'(1);
                    if (rem_q == (AWIDTH+1)'(1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (inflight_q == '0 &&
                    (fifo_count == '0 || (fifo_count == CW'(1) && pop))) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            raddr_q    <= '0;
            tag_vld_q  <= '0;
            tag_last_q <= '0;
            inflight_q <= '0;
            run_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            run_q   <= 1'b1;
            done_q  <= done_d;
            if (issue) raddr_q <= addr_q;
            tag_vld_q[0]  <= issue;
            tag_last_q[0] <= issue && (rem_q == (AWIDTH+1)'(1));
            for (int i = 1; i < LAT; i++) begin
                tag_vld_q[i]  <= tag_vld_q[i-1];
                tag_last_q[i] <= tag_last_q[i-1];
            end
            case ({issue, capture})
                2'b10:   inflight_q <= inflight_q + IW'(1);
                2'b01:   inflight_q <= inflight_q - IW'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    sr_fifo #(
        .WIDTH (DWIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (capture),
        .push_dat ({read_data, tag_last_q[LAT-1]}),
        .pop_vld  (out_valid),
        .pop_rdy  (out_ready),
        .pop_dat  ({out_data, out_last}),
        .count    (fifo_count)
    );

    assign mem_enable   = run_q;
    assign cmd_ready    = run_q && (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign read_address = issue ? addr_q : raddr_q;
endmodule

// File: tb/tb_sram_read_streamer.sv
// Directed bench for sram_read_streamer against a behavioural pipelined SRAM holding mem[i] = i.
module tb_sram_read_streamer;
    localparam int AW = 12;
    localparam int DW = 72;
    localparam int NB = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [AW:0]   cmd_len;
    logic          mem_enable;
    logic [AW-1:0] read_address;
    logic [DW-1:0] read_data;
    logic          out_valid, out_ready, out_last, busy, done;
    logic [DW-1:0] out_data;

    int checks   = 0;
    int failures = 0;

    sram_read_streamer #(
        .AWIDTH(AW), .DWIDTH(DW), .NBPIPE(NB), .FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .mem_enable(mem_enable), .read_address(read_address), .read_data(read_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // SRAM model: NB+1 register stages, so data appears NB+1 cycles after its address.
    logic [DW-1:0] pipe [NB+1];
    always @(posedge clk) begin
        if (mem_enable) begin
            pipe[0] <= {60'b0, read_address};
            for (int i = 1; i <= NB; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign read_data = pipe[NB];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Entered just after a negedge with out_ready=1; k counts negedges from entry.
    task automatic collect(input logic [AW-1:0] a, input int n, input int maxk, input string tag,
                           output int first, output int lastk, output int donek);
        int got;
        logic [AW-1:0] e;
        got = 0; first = -1; lastk = -1; donek = -1;
        for (int k = 0; k < maxk; k++) begin
            if (out_valid) begin
                e = a + got[AW-1:0];
                if (first < 0) first = k;
                check({tag, "_data"}, out_data, {60'b0, e});
                check({tag, "_last"}, DW'(out_last), DW'(got == n - 1));
                if (out_last) lastk = k;
                got++;
            end
            if (done && donek < 0) donek = k;
            @(negedge clk);
        end
        check({tag, "_count"}, DW'(got), DW'(n));
    endtask

    task automatic burst(input logic [AW-1:0] a, input int n, input string tag);
        int first, lastk, donek;
        @(negedge clk);
        out_ready = 1'b1; cmd_valid = 1'b1; cmd_addr = a; cmd_len = 13'(n);
        check({tag, "_cmd_ready"}, DW'(cmd_ready), DW'(1));
        @(negedge clk);
        cmd_valid = 1'b0;
        check({tag, "_busy"}, DW'(busy), DW'(1));
        collect(a, n, n + 12, tag, first, lastk, donek);
        check({tag, "_first_lat"}, DW'(first + 1), DW'(6));
        check({tag, "_last_cyc"}, DW'(lastk + 1), DW'(5 + n));
        check({tag, "_done_cyc"}, DW'(donek + 1), DW'(6 + n));
    endtask

    initial begin
        int first, lastk, donek;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; out_ready = 1'b0;

        // Reset values, then enable/ready on the first cycle after release
        repeat (3) @(negedge clk);
        check("rst_mem_enable", DW'(mem_enable), DW'(0));
        check("rst_cmd_ready", DW'(cmd_ready), DW'(0));
        check("rst_out_valid", DW'(out_valid), DW'(0));
        check("rst_busy", DW'(busy), DW'(0));
        check("rst_done", DW'(done), DW'(0));
        check("rst_read_address", DW'(read_address), DW'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_mem_enable", DW'(mem_enable), DW'(1));
        check("rel_cmd_ready", DW'(cmd_ready), DW'(1));

        // Basic burst and address wrap
        burst(12'h010, 4, "basic");
        burst(12'hFFE, 4, "wrap");

        // Zero-length command: done pulse only, no read issued
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 12'h055; cmd_len = '0;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("zero_done", DW'(done), DW'(1));
        check("zero_cmd_ready", DW'(cmd_ready), DW'(1));
        check("zero_busy", DW'(busy), DW'(0));
        check("zero_out_valid", DW'(out_valid), DW'(0));
        check("zero_read_address", DW'(read_address), DW'(12'h001));
        @(negedge clk);
        check("zero_done_clear", DW'(done), DW'(0));
        check("zero_out_valid2", DW'(out_valid), DW'(0));

        // Backpressure: issue must stop after 8 reads, head word held
        @(negedge clk);
        out_ready = 1'b0; cmd_valid = 1'b1; cmd_addr = 12'h100; cmd_len = 13'd20;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (15) @(negedge clk);
        check("bp_valid", DW'(out_valid), DW'(1));
        check("bp_data", out_data, DW'(12'h100));
        check("bp_last", DW'(out_last), DW'(0));
        check("bp_read_address", DW'(read_address), DW'(12'h107));
        check("bp_busy", DW'(busy), DW'(1));
        repeat (5) @(negedge clk);
        check("bp_hold_data", out_data, DW'(12'h100));
        check("bp_hold_address", DW'(read_address), DW'(12'h107));
        out_ready = 1'b1;
        collect(12'h100, 20, 40, "bp", first, lastk, donek);
        check("bp_first", DW'(first), DW'(0));
        check("bp_last_cyc", DW'(lastk), DW'(19));
        check("bp_done_cyc", DW'(donek), DW'(20));

        // Reset in the middle of a burst after three words
        @(negedge clk);
        out_ready = 1'b1; cmd_valid = 1'b1; cmd_addr = 12'h200; cmd_len = 13'd10;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("mid_data", out_data, {60'b0, 12'(12'h200 + i)});
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", DW'(out_valid), DW'(0));
        check("mid_rst_out_data", out_data, DW'(0));
        check("mid_rst_busy", DW'(busy), DW'(0));
        check("mid_rst_cmd_ready", DW'(cmd_ready), DW'(0));
        check("mid_rst_mem_enable", DW'(mem_enable), DW'(0));
        check("mid_rst_read_address", DW'(read_address), DW'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_out_valid", DW'(out_valid), DW'(0));
        check("post_rst_cmd_ready", DW'(cmd_ready), DW'(1));
        burst(12'h300, 5, "post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
